// File: rtl/ifu_fetch_stage_pkg.sv
// Shared frontend types for the FTQ->IFU->IB path: fetch-block request, IB packet,
// fetch FSM encoding and the slot/taken mask helpers.
package ifu_fetch_stage_pkg;

  localparam int IFU_ADDR_W        = 32;
  localparam int IFU_FETCH_WIDTH   = 4;
  localparam int FRONTEND_FTQ_SIZE = 8;
  localparam int FTQ_ID_W          = $clog2(FRONTEND_FTQ_SIZE);
  // One spare bit so the FTQ can express lengths beyond the fetch width.
  localparam int LEN_W             = $clog2(IFU_FETCH_WIDTH) + 2;

  typedef logic [IFU_FETCH_WIDTH-1:0] slot_mask_t;

  typedef struct packed {
    logic                  valid;
    logic [IFU_ADDR_W-1:0] start_pc;
    logic [LEN_W-1:0]      length;
    logic                  is_cross_cacheline;
    logic                  predicted_taken;
  } ftq_ifu_t;

  typedef struct packed {
    logic [IFU_ADDR_W-1:0]                 start_pc;
    logic [IFU_FETCH_WIDTH-1:0][31:0]      inst;
    slot_mask_t                            slot_mask;
    slot_mask_t                            taken_mask;
    logic [FTQ_ID_W-1:0]                   ftq_id;
  } ifu_ib_t;

  typedef enum logic [1:0] {
    ST_IDLE      = 2'd0,
    ST_WAIT_RESP = 2'd1,
    ST_DISCARD   = 2'd2
  } fetch_state_e;

  // Lengths above the fetch width naturally saturate to all ones.
  function automatic slot_mask_t slot_mask_f(input logic [LEN_W-1:0] len);
    slot_mask_t m;
    for (int i = 0; i < IFU_FETCH_WIDTH; i++) begin
      m[i] = (LEN_W'(i) < len);
    end
    return m;
  endfunction

  function automatic slot_mask_t taken_mask_f(input logic [LEN_W-1:0] len,
                                              input logic             taken);
    slot_mask_t       m;
    logic [LEN_W-1:0] sat;
    sat = (len > LEN_W'(IFU_FETCH_WIDTH)) ? LEN_W'(IFU_FETCH_WIDTH) : len;
    for (int i = 0; i < IFU_FETCH_WIDTH; i++) begin
      m[i] = taken & (LEN_W'(i + 1) == sat);
    end
    return m;
  endfunction

endpackage

// File: rtl/ifu_fetch_stage.sv
// IFU fetch stage: accepts one FTQ block at a time, issues a single I-cache read,
// drops stale responses and presents surviving blocks to the IB from one register.
module ifu_fetch_stage
  import ifu_fetch_stage_pkg::*;
#(
  parameter int ADDR_WIDTH  = IFU_ADDR_W,
  parameter int FETCH_WIDTH = IFU_FETCH_WIDTH,
  parameter int FTQ_SIZE    = FRONTEND_FTQ_SIZE
) (
  input  logic                        clk,
  input  logic                        rst,
  input  ftq_ifu_t                    ftq_i,
  input  logic [$clog2(FTQ_SIZE)-1:0] ftq_id_i,
  input  logic                        ftq_redirect_i,
  output logic                        ftq_accept_o,
  input  logic                        backend_flush_i,
  output logic                        icache_rreq_o,
  output logic [ADDR_WIDTH-1:0]       icache_raddr_o,
  output logic                        icache_cross_o,
  input  logic                        icache_rreq_ready_i,
  input  logic                        icache_rvalid_i,
  input  logic [FETCH_WIDTH*32-1:0]   icache_rdata_i,
  output logic                        ib_valid_o,
  input  logic                        ib_ready_i,
  output ifu_ib_t                     ib_o
);

  fetch_state_e                  state_q, state_d;
  logic                          buf_valid_q, buf_valid_d;
  ifu_ib_t                       ib_q, ib_d;
  logic [ADDR_WIDTH-1:0]         req_pc_q, req_pc_d;
  logic [LEN_W-1:0]              req_len_q, req_len_d;
  logic                          req_taken_q, req_taken_d;
  logic [$clog2(FTQ_SIZE)-1:0]   req_id_q, req_id_d;

  logic buf_free;
  logic kill;
  logic rreq;
  logic accept;

  assign buf_free = ~buf_valid_q | ib_ready_i;
  assign kill     = ftq_redirect_i | backend_flush_i;
  assign rreq     = ftq_i.valid & (state_q == ST_IDLE) & buf_free & ~kill & ~rst;
  assign accept   = rreq & icache_rreq_ready_i;

  assign icache_rreq_o  = rreq;
  assign ftq_accept_o   = accept;
  assign icache_raddr_o = ftq_i.start_pc;
  assign icache_cross_o = ftq_i.is_cross_cacheline;
  assign ib_valid_o     = buf_valid_q;
  assign ib_o           = ib_q;

  always_comb begin
    state_d     = state_q;
    buf_valid_d = buf_valid_q;
    ib_d        = ib_q;
    req_pc_d    = req_pc_q;
    req_len_d   = req_len_q;
    req_taken_d = req_taken_q;
    req_id_d    = req_id_q;

    if (buf_valid_q && ib_ready_i) begin
      buf_valid_d = 1'b0;
    end

    unique case (state_q)
      ST_IDLE: begin
        if (accept) begin
          req_pc_d    = ftq_i.start_pc;
          req_len_d   = ftq_i.length;
          req_taken_d = ftq_i.predicted_taken;
          req_id_d    = ftq_id_i;
          state_d     = ST_WAIT_RESP;
        end
      end
      ST_WAIT_RESP: begin
        if (icache_rvalid_i) begin
          // A kill arriving with the data drops it without touching the buffer.
          if (!kill) begin
            ib_d.start_pc   = req_pc_q;
            ib_d.inst       = icache_rdata_i;
            ib_d.slot_mask  = slot_mask_f(req_len_q);
            ib_d.taken_mask = taken_mask_f(req_len_q, req_taken_q);
            ib_d.ftq_id     = req_id_q;
            buf_valid_d     = 1'b1;
          end
          state_d = ST_IDLE;
        end else if (kill) begin
          state_d = ST_DISCARD;
        end
      end
      ST_DISCARD: begin
        if (icache_rvalid_i) begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    if (backend_flush_i) begin
      buf_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      buf_valid_q <= 1'b0;
      ib_q        <= '0;
    end else begin
      state_q     <= state_d;
      buf_valid_q <= buf_valid_d;
      ib_q        <= ib_d;
    end
  end

  // Request bookkeeping is only meaningful while a read is outstanding.
  always_ff @(posedge clk) begin
    req_pc_q    <= req_pc_d;
    req_len_q   <= req_len_d;
    req_taken_q <= req_taken_d;
    req_id_q    <= req_id_d;
  end

endmodule

// File: tb/tb_ifu_fetch_stage.sv
// Randomized bench for ifu_fetch_stage: a transaction-level model of the fetch stage
// and an I-cache responder predict every output each cycle.
module tb_ifu_fetch_stage;
  import ifu_fetch_stage_pkg::*;

  logic                clk;
  logic                rst;
  ftq_ifu_t            ftq_i;
  logic [FTQ_ID_W-1:0] ftq_id_i;
  logic                ftq_redirect_i;
  logic                ftq_accept_o;
  logic                backend_flush_i;
  logic                icache_rreq_o;
  logic [31:0]         icache_raddr_o;
  logic                icache_cross_o;
  logic                icache_rreq_ready_i;
  logic                icache_rvalid_i;
  logic [127:0]        icache_rdata_i;
  logic                ib_valid_o;
  logic                ib_ready_i;
  ifu_ib_t             ib_o;

  ifu_fetch_stage dut (
    .clk                 (clk),
    .rst                 (rst),
    .ftq_i               (ftq_i),
    .ftq_id_i            (ftq_id_i),
    .ftq_redirect_i      (ftq_redirect_i),
    .ftq_accept_o        (ftq_accept_o),
    .backend_flush_i     (backend_flush_i),
    .icache_rreq_o       (icache_rreq_o),
    .icache_raddr_o      (icache_raddr_o),
    .icache_cross_o      (icache_cross_o),
    .icache_rreq_ready_i (icache_rreq_ready_i),
    .icache_rvalid_i     (icache_rvalid_i),
    .icache_rdata_i      (icache_rdata_i),
    .ib_valid_o          (ib_valid_o),
    .ib_ready_i          (ib_ready_i),
    .ib_o                (ib_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  task automatic chk(input string tag, input logic [255:0] got, input logic [255:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Transaction-level reference state
  bit          m_busy;       // a read is outstanding
  bit          m_stale;      // the outstanding read will be thrown away
  int          m_cnt;        // cycles until the I-cache answers
  logic [31:0] m_pc;
  int          m_len;
  bit          m_taken;
  int          m_id;
  bit          m_bvalid;
  ifu_ib_t     m_buf;

  function automatic ifu_ib_t make_pkt(input logic [31:0] pc, input int len, input bit taken,
                                       input int id, input logic [127:0] data);
    ifu_ib_t p;
    int      eff;
    eff          = (len > 4) ? 4 : len;
    p.start_pc   = pc;
    p.inst       = data;
    p.slot_mask  = 4'((1 << eff) - 1);
    p.taken_mask = (taken && eff > 0) ? 4'(1 << (eff - 1)) : 4'b0;
    p.ftq_id     = 3'(id);
    return p;
  endfunction

  initial begin
    bit ib_slow;
    bit exp_rreq, exp_acc;
    bit nb;

    rst = 1'b1;
    ftq_i = '0;
    ftq_id_i = '0;
    ftq_redirect_i = 1'b0;
    backend_flush_i = 1'b0;
    icache_rreq_ready_i = 1'b0;
    icache_rvalid_i = 1'b0;
    icache_rdata_i = '0;
    ib_ready_i = 1'b0;
    m_busy = 0; m_stale = 0; m_cnt = 0; m_bvalid = 0; m_buf = '0;
    m_pc = '0; m_len = 0; m_taken = 0; m_id = 0;
    ib_slow = 0;

    for (int cyc = 0; cyc < 4000; cyc++) begin
      @(posedge clk);
      #1;
      rst = (cyc < 3) || (cyc >= 2000 && cyc < 2002);
      if (cyc % 16 == 0) ib_slow = ($urandom_range(0, 2) == 0);
      ftq_i.valid              = ($urandom_range(0, 9) < 7);
      ftq_i.start_pc           = ($urandom_range(0, 3) == 0) ? 32'h1c00_0000 : ($urandom & 32'hffff_fffc);
      ftq_i.length             = LEN_W'($urandom_range(0, 7));
      ftq_i.is_cross_cacheline = 1'($urandom);
      ftq_i.predicted_taken    = 1'($urandom);
      ftq_id_i                 = 3'($urandom);
      ftq_redirect_i           = ($urandom_range(0, 7) == 0);
      backend_flush_i          = ($urandom_range(0, 19) == 0);
      icache_rreq_ready_i      = ($urandom_range(0, 3) != 0);
      ib_ready_i               = ib_slow ? ($urandom_range(0, 7) == 0) : ($urandom_range(0, 3) != 0);
      icache_rvalid_i          = m_busy && (m_cnt == 0);
      icache_rdata_i           = {$urandom, $urandom, $urandom, $urandom};

      #3;
      exp_rreq = ftq_i.valid && !m_busy && (!m_bvalid || ib_ready_i) &&
                 !ftq_redirect_i && !backend_flush_i && !rst;
      exp_acc  = exp_rreq && icache_rreq_ready_i;
      chk("rreq",     256'(icache_rreq_o),  256'(exp_rreq));
      chk("accept",   256'(ftq_accept_o),   256'(exp_acc));
      chk("raddr",    256'(icache_raddr_o), 256'(ftq_i.start_pc));
      chk("cross",    256'(icache_cross_o), 256'(ftq_i.is_cross_cacheline));
      chk("ib_valid", 256'(ib_valid_o),     256'(m_bvalid));
      chk("ib_pkt",   256'(ib_o),           256'(m_buf));

      // Advance the model across the coming clock edge
      nb = m_bvalid && !ib_ready_i;
      if (m_busy && icache_rvalid_i) begin
        m_busy = 0;
        if (!m_stale && !ftq_redirect_i && !backend_flush_i) begin
          m_buf = make_pkt(m_pc, m_len, m_taken, m_id, icache_rdata_i);
          nb = 1;
        end
      end else if (m_busy) begin
        if (ftq_redirect_i || backend_flush_i) m_stale = 1;
        m_cnt--;
      end
      if (exp_acc) begin
        m_busy  = 1;
        m_stale = 0;
        m_cnt   = $urandom_range(0, 3);
        m_pc    = ftq_i.start_pc;
        m_len   = int'(ftq_i.length);
        m_taken = ftq_i.predicted_taken;
        m_id    = int'(ftq_id_i);
      end
      if (backend_flush_i) nb = 0;
      m_bvalid = nb;
      if (rst) begin
        m_busy = 0; m_stale = 0; m_bvalid = 0; m_buf = '0;
      end
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
